// File: rtl/mat_transpose.sv
// Captures a row-major matrix stream into a buffer and replays it column-major on a valid/ready stream.
// Optional build macro MAT_TRANSPOSE_STALL_CNT_EN adds the stall_cycles backpressure counter port.

package mat_transpose_pkg;

    typedef struct packed {
        logic [31:0] rows;
        logic [31:0] cols;
    } matmul_dims_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ERROR = 2'd3
    } transpose_state_t;

endpackage

module mat_transpose
    import mat_transpose_pkg::*;
#(
    parameter int N_MAX_ELS  = 256,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  matmul_dims_t          dims,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output transpose_state_t      state,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output matmul_dims_t          out_dims
`ifdef MAT_TRANSPOSE_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int ADDR_W = (N_MAX_ELS > 1) ? $clog2(N_MAX_ELS) : 1;

    transpose_state_t state_reg, state_next;

    logic [ADDR_W-1:0] wr_idx_reg,   wr_idx_next;
    logic [ADDR_W-1:0] row_reg,      row_next;
    logic [ADDR_W-1:0] col_reg,      col_next;
    logic [ADDR_W-1:0] rd_addr_reg,  rd_addr_next;
    logic [ADDR_W-1:0] last_row_reg, last_row_next;
    logic [ADDR_W-1:0] last_col_reg, last_col_next;
    logic [ADDR_W-1:0] last_idx_reg, last_idx_next;
    logic [ADDR_W-1:0] stride_reg,   stride_next;
    matmul_dims_t      out_dims_reg, out_dims_next;

    logic [DATA_WIDTH-1:0] mem [N_MAX_ELS];
    logic                  mem_we;

    logic [63:0] dims_prod;
    logic        dims_bad;

    // Full 64-bit product so that e.g. 65536x65536 cannot wrap to a small legal size.
    assign dims_prod = {32'd0, dims.rows} * {32'd0, dims.cols};
    assign dims_bad  = (dims.rows == 32'd0) || (dims.cols == 32'd0) ||
                       (dims_prod > 64'(N_MAX_ELS));

    always_comb begin
        state_next    = state_reg;
        wr_idx_next   = wr_idx_reg;
        row_next      = row_reg;
        col_next      = col_reg;
        rd_addr_next  = rd_addr_reg;
        last_row_next = last_row_reg;
        last_col_next = last_col_reg;
        last_idx_next = last_idx_reg;
        stride_next   = stride_reg;
        out_dims_next = out_dims_reg;
        out_valid     = 1'b0;
        mem_we        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (dims_bad) begin
                        state_next = ERROR;
                    end else begin
                        // Dims are known to fit the buffer here, so the narrowing casts are lossless
                        // (stride may truncate only when rows==1, where it is never used).
                        state_next         = READ;
                        wr_idx_next        = '0;
                        last_row_next      = ADDR_W'(dims.rows - 32'd1);
                        last_col_next      = ADDR_W'(dims.cols - 32'd1);
                        last_idx_next      = ADDR_W'(dims_prod - 64'd1);
                        stride_next        = ADDR_W'(dims.cols);
                        out_dims_next.rows = dims.cols;
                        out_dims_next.cols = dims.rows;
                    end
                end
            end

            ERROR: begin
                if (!start) begin
                    state_next = IDLE;
                end
            end

            READ: begin
                if (in_valid) begin
                    mem_we      = 1'b1;
                    wr_idx_next = wr_idx_reg + ADDR_W'(1);
                    if (wr_idx_reg == last_idx_reg) begin
                        state_next   = WRITE;
                        wr_idx_next  = '0;
                        row_next     = '0;
                        col_next     = '0;
                        rd_addr_next = '0;
                    end
                end
            end

            WRITE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    // rd_addr tracks row*cols + col incrementally instead of multiplying.
                    if (row_reg == last_row_reg) begin
                        row_next     = '0;
                        col_next     = col_reg + ADDR_W'(1);
                        rd_addr_next = col_reg + ADDR_W'(1);
                        if (col_reg == last_col_reg) begin
                            state_next   = IDLE;
                            col_next     = '0;
                            rd_addr_next = '0;
                        end
                    end else begin
                        row_next     = row_reg + ADDR_W'(1);
                        rd_addr_next = rd_addr_reg + stride_reg;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            wr_idx_reg   <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            rd_addr_reg  <= '0;
            last_row_reg <= '0;
            last_col_reg <= '0;
            last_idx_reg <= '0;
            stride_reg   <= '0;
            out_dims_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wr_idx_reg   <= wr_idx_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            rd_addr_reg  <= rd_addr_next;
            last_row_reg <= last_row_next;
            last_col_reg <= last_col_next;
            last_idx_reg <= last_idx_next;
            stride_reg   <= stride_next;
            out_dims_reg <= out_dims_next;
        end
    end

    // Buffer is deliberately not reset; only the indices are.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx_reg] <= in_data;
        end
    end

    assign out_data = mem[rd_addr_reg];
    assign state    = state_reg;
    assign out_dims = out_dims_reg;

`ifdef MAT_TRANSPOSE_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == IDLE) && start && !dims_bad) begin
            stall_cnt_reg <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_mat_transpose.sv
// Directed and randomized bench for mat_transpose; expected output order comes from a
// row/column reference model built from the captured input stream.

module tb_mat_transpose;
    import mat_transpose_pkg::*;

    localparam int N  = 256;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    matmul_dims_t     dims = '0;
    logic             in_valid = 1'b0;
    logic [DW-1:0]    in_data = '0;
    transpose_state_t state;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    out_data;
    matmul_dims_t     out_dims;
`ifdef MAT_TRANSPOSE_STALL_CNT_EN
    logic [31:0]      stall_cycles;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;
    int read_cycles = 0;
    int model_stalls = 0;

    logic [DW-1:0] in_q[$];
    logic [DW-1:0] exp_q[$];
    bit            ready_pat[$];

    mat_transpose #(.N_MAX_ELS(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .dims      (dims),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .state     (state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dims  (out_dims)
`ifdef MAT_TRANSPOSE_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: element (r,c) of the row-major stream emitted with c outer, r inner.
    task automatic build_expected(input int r, input int c);
        exp_q.delete();
        for (int ci = 0; ci < c; ci++)
            for (int ri = 0; ri < r; ri++)
                exp_q.push_back(in_q[ri * c + ci]);
    endtask

    task automatic fill_random(input int n);
        in_q.delete();
        for (int i = 0; i < n; i++) in_q.push_back($urandom);
    endtask

    task automatic start_xfer(input logic [31:0] r, input logic [31:0] c);
        dims.rows = r;
        dims.cols = c;
        start     = 1'b1;
        t0        = cyc;
        @(negedge clk);
        start = 1'b0;
        check("start_read", 64'(state), 64'(READ));
        check("out_dims_latch", out_dims, {c, r});
    endtask

    task automatic feed(input bit gaps_alt, input bit gaps_rand);
        int g;
        read_cycles = 0;
        for (int i = 0; i < in_q.size(); i++) begin
            if (state == READ) read_cycles++;
            if (gaps_rand) start = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            in_data  = in_q[i];
            @(negedge clk);
            g = gaps_alt ? 1 : (gaps_rand ? int'($urandom_range(0, 2)) : 0);
            if (i < in_q.size() - 1) begin
                for (int j = 0; j < g; j++) begin
                    if (state == READ) read_cycles++;
                    in_valid = 1'b0;
                    in_data  = $urandom;
                    @(negedge clk);
                end
            end
        end
        in_valid = 1'b0;
        if (gaps_rand) start = 1'b0;
        check("enter_write", 64'(state), 64'(WRITE));
        check("valid_on_write", 64'(out_valid), 64'd1);
    endtask

    task automatic drain(input int max_out, input bit rand_ready);
        int            k = 0;
        int            guard = 0;
        bit            prev_stall = 1'b0;
        bit            rdy;
        logic [DW-1:0] prev_data = '0;
        model_stalls = 0;
        while (k < max_out && guard < 4000) begin
            guard++;
            if (out_valid !== 1'b1) begin
                check("out_valid_in_write", 64'(out_valid), 64'd1);
                break;
            end
            if (prev_stall) check("stall_hold", out_data, prev_data);
            if (ready_pat.size() > 0) rdy = ready_pat.pop_front();
            else rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            check("out_data", out_data, exp_q[k]);
            if (rdy) k++;
            else model_stalls++;
            prev_stall = !rdy;
            prev_data  = out_data;
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (guard >= 4000) check("drain_timeout", 64'(k), 64'(max_out));
    endtask

    task automatic finish_checks(input int r, input int c);
        check("back_to_idle", 64'(state), 64'(IDLE));
        check("valid_low_idle", 64'(out_valid), 64'd0);
`ifdef MAT_TRANSPOSE_STALL_CNT_EN
        check("stall_count", 64'(stall_cycles), 64'(model_stalls));
`endif
        $display("xfer %0dx%0d done, stalls=%0d", r, c, model_stalls);
    endtask

    initial begin
        logic [31:0] bad_r[6];
        logic [31:0] bad_c[6];
        int          fr[3];
        int          fc[3];
        int          r;
        int          c;
        bad_r = '{32'd1000, 32'd0, 32'd4, 32'd17, 32'h10000, 32'd257};
        bad_c = '{32'd1000, 32'd4, 32'd0, 32'd16, 32'h10000, 32'd1};
        fr    = '{1, 1, 256};
        fc    = '{1, 256, 1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_state", 64'(state), 64'(IDLE));
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_dims", out_dims, 64'd0);
`ifdef MAT_TRANSPOSE_STALL_CNT_EN
        check("rst_stall", 64'(stall_cycles), 64'd0);
`endif
        rstn = 1'b1;
        @(negedge clk);

        // Basic 2x3
        in_q = '{1, 2, 3, 4, 5, 6};
        start_xfer(2, 3);
        feed(1'b0, 1'b0);
        build_expected(2, 3);
        drain(6, 1'b0);
        check("idle_latency", 64'(cyc - t0), 64'd13);
        check("dims_2x3", out_dims, {32'd3, 32'd2});
        finish_checks(2, 3);

        // Bad dims: ERROR, sticky while start high even with good dims
        for (int i = 0; i < 6; i++) begin
            dims.rows = bad_r[i];
            dims.cols = bad_c[i];
            start     = 1'b1;
            @(negedge clk);
            check("bad_dims_error", 64'(state), 64'(ERROR));
            check("error_valid", 64'(out_valid), 64'd0);
            dims = '{rows: 32'd2, cols: 32'd2};
            @(negedge clk);
            check("error_sticky", 64'(state), 64'(ERROR));
            start = 1'b0;
            @(negedge clk);
            check("error_release", 64'(state), 64'(IDLE));
            check("error_dims_hold", out_dims, {32'd3, 32'd2});
            $display("bad dims %0dx%0d rejected", bad_r[i], bad_c[i]);
        end

        // Input gaps
        in_q = '{7, 8, 9, 10};
        start_xfer(2, 2);
        feed(1'b1, 1'b0);
        check("read_len_gaps", 64'(read_cycles), 64'd7);
        build_expected(2, 2);
        check("exp_order", {exp_q[0], exp_q[1]}, {32'd7, 32'd9});
        drain(4, 1'b0);
        finish_checks(2, 2);

        // Backpressure
        start_xfer(2, 2);
        feed(1'b0, 1'b0);
        ready_pat = '{1, 0, 0, 1, 1, 0, 1};
        drain(4, 1'b0);
        check("bp_stalls_model", 64'(model_stalls), 64'd3);
        finish_checks(2, 2);

        // Reset mid-WRITE
        fill_random(256);
        start_xfer(16, 16);
        feed(1'b0, 1'b0);
        build_expected(16, 16);
        drain(2, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_state", 64'(state), 64'(IDLE));
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_dims", out_dims, 64'd0);
`ifdef MAT_TRANSPOSE_STALL_CNT_EN
        check("midrst_stall", 64'(stall_cycles), 64'd0);
`endif
        rstn = 1'b1;
        $display("reset mid-write applied");
        in_q.delete();
        for (int i = 0; i < 256; i++) in_q.push_back(DW'(i));
        start_xfer(16, 16);
        feed(1'b0, 1'b0);
        exp_q.delete();
        for (int k = 0; k < 256; k++) exp_q.push_back(DW'((k % 16) * 16 + k / 16));
        drain(256, 1'b0);
        finish_checks(16, 16);

        // Back-to-back with start held across the final handshake
        fill_random(4);
        start_xfer(2, 2);
        feed(1'b0, 1'b0);
        build_expected(2, 2);
        dims  = '{rows: 32'd3, cols: 32'd1};
        start = 1'b1;
        drain(4, 1'b0);
        check("b2b_idle", 64'(state), 64'(IDLE));
        @(negedge clk);
        start = 1'b0;
        check("b2b_read", 64'(state), 64'(READ));
        check("b2b_dims", out_dims, {32'd1, 32'd3});
        fill_random(3);
        feed(1'b0, 1'b0);
        build_expected(3, 1);
        drain(3, 1'b1);
        finish_checks(3, 1);

        // Shape boundaries
        for (int i = 0; i < 3; i++) begin
            fill_random(fr[i] * fc[i]);
            start_xfer(fr[i], fc[i]);
            feed(1'b0, 1'b1);
            build_expected(fr[i], fc[i]);
            drain(fr[i] * fc[i], 1'b1);
            finish_checks(fr[i], fc[i]);
        end

        // Random shapes, gaps and backpressure
        for (int t = 0; t < 8; t++) begin
            r = $urandom_range(1, 8);
            c = $urandom_range(1, 8);
            fill_random(r * c);
            start_xfer(r, c);
            feed(1'b0, 1'b1);
            build_expected(r, c);
            drain(r * c, 1'b1);
            finish_checks(r, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mat_transpose.md
# mat_transpose

Downstream stage for `matmul`. Captures one result matrix streamed in row-major order, one element per cycle, from `matmul`'s `out_c`. Replays it in column-major order, i.e. transposed, on a valid/ready output stream. The consumer can therefore apply backpressure, which `matmul` itself cannot.

## Interface
Parameters:
- `N_MAX_ELS`, default 256: buffer depth in elements; sized for 16x16 results.
- `DATA_WIDTH`, default 32: element width; matches `int`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin capture; sampled in IDLE and ERROR only.
- `dims`  in  `matmul_dims_t` (rows, cols; 32 b each)  dimensions of the incoming matrix; sampled when `start` is accepted.
- `in_valid`  in  1  `in_data` carries the next row-major element.
- `in_data`  in  DATA_WIDTH  input element.
- `state`  out  `transpose_state_t`  one of IDLE, READ, WRITE, ERROR.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts `out_data`.
- `out_data`  out  DATA_WIDTH  transposed element.
- `out_dims`  out  `matmul_dims_t`  {rows = latched cols, cols = latched rows}.

## Operation
- **IDLE**
  - With `start`=1, latch `dims`.
  - If rows==0, cols==0, or rows*cols > N_MAX_ELS (product computed 64 b, no overflow), go to ERROR.
  - Otherwise go to READ and clear the write index.
- **ERROR**
  - Stay while `start`=1; return to IDLE when `start`=0.
  - `out_valid`=0.
- **READ**
  - On each edge with `in_valid`=1: `buf[wr_idx] <= in_data`, then `wr_idx++`.
  - When the element at index rows*cols-1 is accepted, go to WRITE and clear `col`/`row` to 0.
  - `start` is ignored.
- **WRITE**
  - `out_valid`=1.
  - `out_data` = `buf[row*cols + col]`, a combinational read of the registered indices.
  - On each handshake (`out_valid`&&`out_ready`):
    - `row++`.
    - If `row` was rows-1: `row`=0, `col++`.
    - If `col` was also cols-1: go to IDLE.
  - `in_valid` is ignored.
- `out_dims` updates when `start` is accepted into READ and holds until the next accepted start.
- Output order is column-major: `col` is the outer loop, `row` the inner loop.

Reset values (any state, including mid-READ or mid-WRITE):
- `state`=IDLE; `out_valid`=0.
- `out_dims`={0,0}; all indices 0.
- Buffer contents are not cleared.

## Timing
- `start` accepted at edge E: `state`=READ is visible after E. The first element can be accepted at E+1.
- The last input is accepted at edge L: `state`=WRITE and `out_valid`=1 are visible after L. Latency is 1 cycle.
- Minimum transfer (no gaps, `out_ready` held 1): 1 + 2·rows·cols cycles from `start` back to IDLE.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data` and the indices hold stable.
- Last handshake at edge H: `state`=IDLE and `out_valid`=0 after H.
- `start` held 1 through H is not accepted until the next edge: IDLE must be observed for one cycle.
- `start` during ERROR with good dims: no effect; `start` must drop first.
- To feed straight from `matmul`: tie `in_valid` to (`matmul.state`==WRITE) delayed one cycle, matching `matmul`'s registered `out_c`.

## Configuration
- `MAT_TRANSPOSE_STALL_CNT_EN` defined:
  - Adds output `stall_cycles` (32 b).
  - Cleared to 0 on reset and on accepted `start`.
  - Increments on every cycle with `out_valid`=1 and `out_ready`=0; saturates at 2^32-1.
- Not defined: port and counter absent; behaviour otherwise identical.

## Test plan
1. **Basic 2x3:**
   - Stimulus: dims {2,3}; stream 1,2,3,4,5,6 with `in_valid`=1; `out_ready`=1.
   - Required: `out_data` sequence 1,4,2,5,3,6; `out_dims`={3,2}.
   - Required: IDLE 13 cycles after `start`.
2. **Bad dims:**
   - Stimulus: dims {1000,1000} with `start`=1. Required: ERROR next cycle.
   - Stimulus: `start`=0. Required: IDLE.
   - Stimulus: repeat with dims {0,4}. Required: ERROR.
3. **Input gaps:**
   - Stimulus: dims {2,2}; data 7,8,9,10 with `in_valid` alternating 1,0.
   - Required: READ lasts 7 cycles; output 7,9,8,10.
4. **Backpressure:**
   - Stimulus: 2x2 with `out_ready` pattern 1,0,0,1,1,0,1.
   - Required: `out_data` stable through the 0s; output still 7,9,8,10.
   - Required (macro on): `stall_cycles`=3.
5. **Reset mid-WRITE:**
   - Stimulus: 16x16 transfer; after 2 outputs, `rstn`=0 for 1 cycle.
   - Required: `state`=IDLE, `out_valid`=0, `out_dims`={0,0}.
   - Stimulus: new 16x16 transfer with values 0..255.
   - Required: output k equals (k%16)·16 + k/16.
6. **Back-to-back:**
   - Stimulus: `start` held 1 across the end of a 2x2 transfer.
   - Required: one IDLE cycle, then READ with new dims latched.
